// File: rtl/spi_sb_pkg.sv
// Shared definitions for the SPI hard-IP system-bus clients: register map and
// the arbiter state encoding (also imported by the readssr sequencer).
package spi_sb_pkg;

    localparam logic [7:0] SPIIRQ   = 8'h06;
    localparam logic [7:0] SPIIRQEN = 8'h07;
    localparam logic [7:0] SPICR0   = 8'h08;
    localparam logic [7:0] SPICR1   = 8'h09;
    localparam logic [7:0] SPICR2   = 8'h0A;
    localparam logic [7:0] SPIBR    = 8'h0B;
    localparam logic [7:0] SPISR    = 8'h0C;
    localparam logic [7:0] SPITXDR  = 8'h0D;
    localparam logic [7:0] SPIRXDR  = 8'h0E;
    localparam logic [7:0] SPICSR   = 8'h0F;

    typedef enum logic [3:0] {
        S_LOAD,
        S_WAIT_DONE,
        S_CFG,
        S_CFG_ACK,
        S_CFG_ACKLO,
        S_IDLE,
        S_XFER,
        S_ACK,
        S_ACKLO
    } sb_state_t;

endpackage

// File: rtl/spi_sb_arbiter_rr_arb2.sv
// Two-way round-robin selector: with both requesting, the one that was not
// served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    assign valid = |req;
    assign grant = (&req) ? ~last : req[1];

endmodule

// File: rtl/spi_sb_arbiter.sv
// System-bus owner for the SPI hard IP: runs IP load and master-mode setup,
// then serves single-byte register accesses from two requesters.
module spi_sb_arbiter
    import spi_sb_pkg::*;
#(
    parameter logic [7:0]  CFG_ADDR = 8'h0A,
    parameter logic [7:0]  CFG_DATA = 8'h80,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ipload,
    input  logic        ipdone,
    output logic        sb_wr,
    output logic        sb_stb,
    output logic [7:0]  sb_adr,
    output logic [7:0]  sb_dat_o,
    input  logic [7:0]  sb_dat_i,
    input  logic        sb_ack,
    input  logic [1:0]  req,
    input  logic [1:0]  req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        ready
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    sb_state_t  state_reg;
    logic [7:0] cnt_reg;
    logic       rr_reg;
    logic       grant_reg;
    logic       we_reg;
    logic [7:0] addr_reg;
    logic [7:0] wdata_reg;

    logic       arb_grant;
    logic       arb_valid;
    logic [7:0] addr_arr  [2];
    logic [7:0] wdata_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*8 +: 8];
            assign wdata_arr[gi] = req_wdata[gi*8 +: 8];
        end
    endgenerate

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (rr_reg),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_LOAD;
            cnt_reg   <= '0;
            rr_reg    <= 1'b0;
            grant_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ipload    <= 1'b0;
            sb_wr     <= 1'b0;
            sb_stb    <= 1'b0;
            sb_adr    <= '0;
            sb_dat_o  <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            ready     <= 1'b0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    ipload    <= 1'b1;
                    state_reg <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (ipdone) begin
                        ipload    <= 1'b0;
                        state_reg <= S_CFG;
                    end
                end
                S_CFG: begin
                    sb_stb    <= 1'b1;
                    sb_wr     <= 1'b1;
                    sb_adr    <= CFG_ADDR;
                    sb_dat_o  <= CFG_DATA;
                    cnt_reg   <= '0;
                    state_reg <= S_CFG_ACK;
                end
                S_CFG_ACK: begin
                    // The configuration write is mandatory, so a missing ack retries forever.
                    if (sb_ack || cnt_reg == TO_LAST) begin
                        sb_stb    <= 1'b0;
                        sb_wr     <= 1'b0;
                        sb_adr    <= '0;
                        sb_dat_o  <= '0;
                        state_reg <= sb_ack ? S_CFG_ACKLO : S_CFG;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                S_CFG_ACKLO: begin
                    if (!sb_ack) begin
                        ready     <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (arb_valid) begin
                        grant_reg <= arb_grant;
                        we_reg    <= req_we[arb_grant];
                        addr_reg  <= addr_arr[arb_grant];
                        wdata_reg <= wdata_arr[arb_grant];
                        state_reg <= S_XFER;
                    end
                end
                S_XFER: begin
                    sb_stb    <= 1'b1;
                    sb_wr     <= we_reg;
                    sb_adr    <= addr_reg;
                    sb_dat_o  <= wdata_reg;
                    cnt_reg   <= '0;
                    state_reg <= S_ACK;
                end
                S_ACK: begin
                    if (sb_ack || cnt_reg == TO_LAST) begin
                        if (sb_ack && !we_reg) begin
                            rdata <= sb_dat_i;
                        end
                        sb_stb    <= 1'b0;
                        sb_wr     <= 1'b0;
                        sb_adr    <= '0;
                        sb_dat_o  <= '0;
                        done      <= grant_reg ? 2'b10 : 2'b01;
                        err       <= ~sb_ack;
                        rr_reg    <= grant_reg;
                        state_reg <= S_ACKLO;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                S_ACKLO: begin
                    done <= '0;
                    if (!sb_ack) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sb_arbiter.sv
// Randomised bench for spi_sb_arbiter with a behavioural SPI-IP bus model and
// a transaction-level reference model of arbitration, timeout and read data.
module tb_spi_sb_arbiter;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ipload, ipdone;
    logic        sb_wr, sb_stb, sb_ack;
    logic [7:0]  sb_adr, sb_dat_o, sb_dat_i;
    logic [1:0]  req, req_we, done;
    logic [15:0] req_addr, req_wdata;
    logic        err, ready;
    logic [7:0]  rdata;

    spi_sb_arbiter #(.CFG_ADDR(8'h0A), .CFG_DATA(8'h80), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ipload    (ipload),
        .ipdone    (ipdone),
        .sb_wr     (sb_wr),
        .sb_stb    (sb_stb),
        .sb_adr    (sb_adr),
        .sb_dat_o  (sb_dat_o),
        .sb_dat_i  (sb_dat_i),
        .sb_ack    (sb_ack),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // IP model knobs and observations
    int         ack_lat = 2;
    bit         ack_never = 0;
    logic [7:0] rd_val = 8'h00;
    int         stb_cnt = 0, load_cnt = 0, load_len = 0, last_len = 0, xfer_n = 0;
    logic       cap_wr = 1'b0;
    logic [7:0] cap_adr = 8'h00, cap_dat = 8'h00;
    bit         unstable = 0;

    initial begin
        ipdone = 1'b0; sb_ack = 1'b0; sb_dat_i = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                stb_cnt = 0; load_cnt = 0; xfer_n = 0;
                ipdone = 1'b0; sb_ack = 1'b0;
            end else begin
                if (ipload) begin
                    load_cnt++;
                    if (load_cnt >= 3) ipdone = 1'b1;
                end else if (load_cnt > 0) begin
                    load_len = load_cnt;
                    load_cnt = 0;
                end
                if (sb_stb) begin
                    if (stb_cnt == 0) begin
                        cap_wr = sb_wr; cap_adr = sb_adr; cap_dat = sb_dat_o; unstable = 0;
                    end else if ({sb_wr, sb_adr, sb_dat_o} !== {cap_wr, cap_adr, cap_dat}) begin
                        unstable = 1;
                    end
                    stb_cnt++;
                    sb_ack = !ack_never && (stb_cnt > ack_lat);
                end else begin
                    if (stb_cnt > 0) begin
                        last_len = stb_cnt;
                        xfer_n++;
                    end
                    stb_cnt = 0;
                    sb_ack = 1'b0;
                end
            end
            sb_dat_i = sb_ack ? rd_val : ~rd_val;
        end
    end

    // Reference model: pending requests, last-served pointer, held read data
    bit         pend [2];
    logic       p_we [2];
    logic [7:0] p_addr [2];
    logic [7:0] p_wdata [2];
    int         rr_m = 0;
    logic [7:0] rdata_m = 8'h00;
    int         txn = 0;

    task automatic post_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
        pend[i] = 1; p_we[i] = we; p_addr[i] = a; p_wdata[i] = d;
        req[i] = 1'b1; req_we[i] = we;
        req_addr[i*8 +: 8] = a; req_wdata[i*8 +: 8] = d;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, ready}, 32'd1);
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_nxfer"}, xfer_n, 32'd1);
        check({tag, "_wr"}, {31'b0, cap_wr}, 32'd1);
        check({tag, "_adr"}, {24'b0, cap_adr}, 32'h0A);
        check({tag, "_dat"}, {24'b0, cap_dat}, 32'h80);
        check({tag, "_ipload_len"}, load_len, 32'd3);
        check({tag, "_ipload_low"}, {31'b0, ipload}, 32'd0);
    endtask

    task automatic serve_one();
        int         g, n, exp_len;
        bit         ok;
        logic [7:0] exp_rd;
        n = 0;
        if (pend[0] && pend[1]) g = 1 - rr_m;
        else g = pend[1] ? 1 : 0;
        ok = !ack_never && (ack_lat + 1 <= TB_TIMEOUT);
        exp_len = ok ? ack_lat + 1 : TB_TIMEOUT;
        exp_rd = (ok && !p_we[g]) ? rd_val : rdata_m;
        while (done == 2'b00 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'b0, done != 2'b00}, 32'd1);
        if (done == 2'b00) return;
        check("done_onehot", {30'b0, done}, (g == 1) ? 32'd2 : 32'd1);
        check("err", {31'b0, err}, {31'b0, !ok});
        check("rdata", {24'b0, rdata}, {24'b0, exp_rd});
        check("bus_wr", {31'b0, cap_wr}, {31'b0, p_we[g]});
        check("bus_adr", {24'b0, cap_adr}, {24'b0, p_addr[g]});
        check("bus_dat", {24'b0, cap_dat}, {24'b0, p_wdata[g]});
        check("stb_len", last_len, exp_len);
        check("bus_stable", {31'b0, unstable}, 32'd0);
        $display("txn %0d: req%0d %s adr=%02h wdata=%02h lat=%0d never=%0d -> done=%b err=%b rdata=%02h",
                 txn, g, p_we[g] ? "WR" : "RD", p_addr[g], p_wdata[g], ack_lat, ack_never,
                 done, err, rdata);
        txn++;
        rdata_m = exp_rd;
        rr_m = g;
        pend[g] = 0;
        req[g] = 1'b0;
        @(negedge clk);
        check("done_pulse", {30'b0, done}, 32'd0);
    endtask

    task automatic random_knobs();
        ack_never = ($urandom_range(0, 7) == 0);
        ack_lat = $urandom_range(0, 9);
        rd_val = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        pend[0] = 0; pend[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {9'b0, ipload, sb_wr, sb_stb, sb_adr, sb_dat_o, done, err, rdata, ready}, 32'd0);

        // Requester 0 posts before configuration completes; it must wait.
        post_req(0, 1'b1, 8'h0D, 8'h81);
        rst = 1'b0;
        wait_ready("ready_after_cfg");
        check_cfg("cfg");
        check("cfg_len", last_len, 32'd3);
        serve_one();

        ack_lat = 1; rd_val = 8'h18;
        post_req(1, 1'b0, 8'h0C, 8'h5A);
        serve_one();

        // Both held continuously: grants must alternate.
        for (int k = 0; k < 4; k++) begin
            ack_never = 0; ack_lat = $urandom_range(0, 3); rd_val = 8'($urandom);
            if (!pend[0]) post_req(0, 1'($urandom), 8'($urandom), 8'($urandom));
            if (!pend[1]) post_req(1, 1'($urandom), 8'($urandom), 8'($urandom));
            serve_one();
        end
        // Finish whatever is still pending from the alternation run.
        while (pend[0] || pend[1]) serve_one();

        // Timeout and its boundaries.
        ack_never = 1; rd_val = 8'hC3;
        post_req(0, 1'b0, 8'h0E, 8'h00);
        serve_one();
        ack_never = 0; ack_lat = 7; rd_val = 8'h7E;
        post_req(1, 1'b0, 8'h0C, 8'h11);
        serve_one();
        ack_lat = 8;
        post_req(0, 1'b0, 8'h0E, 8'h22);
        serve_one();
        ack_lat = 0; rd_val = 8'h3C;
        post_req(1, 1'b0, 8'h0F, 8'h33);
        serve_one();

        for (int k = 0; k < 30; k++) begin
            random_knobs();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    post_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
            end
            if (!pend[0] && !pend[1])
                post_req($urandom_range(0, 1), 1'($urandom), 8'($urandom), 8'($urandom));
            serve_one();
        end
        while (pend[0] || pend[1]) serve_one();

        // Reset in the middle of a strobe.
        ack_never = 1;
        post_req(1, 1'b1, 8'h0D, 8'hA5);
        for (int n = 0; n < 50 && !sb_stb; n++) @(negedge clk);
        check("stb_before_rst", {31'b0, sb_stb}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_stb", {31'b0, sb_stb}, 32'd0);
        check("rst_async_ready", {31'b0, ready}, 32'd0);
        repeat (2) @(negedge clk);
        pend[0] = 0; pend[1] = 0; req = '0;
        rr_m = 0; rdata_m = 8'h00;
        ack_never = 0; ack_lat = 1; rd_val = 8'h96;
        post_req(0, 1'b0, 8'h0C, 8'h01);
        post_req(1, 1'b0, 8'h0E, 8'h02);
        rst = 1'b0;
        @(negedge clk);
        check("ready_low_reload", {31'b0, ready}, 32'd0);
        wait_ready("ready_after_reset");
        check_cfg("recfg");
        serve_one();
        serve_one();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
